// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined control unit: opcodes,
// per-stage control bundles, the bubble constant and the HALT FSM states.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_HALT = 7'b0000000;

    // Full control bundle produced in ID and held in ID/EX.
    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       branch;
        logic       jal;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic       jaltoreg;
    } ctrl_t;

    // Only the fields still needed once the instruction has left EX.
    typedef struct packed {
        logic memread;
        logic memwrite;
        logic regwrite;
        logic memtoreg;
        logic jaltoreg;
    } mem_ctrl_t;

    // Only the fields still needed in write-back.
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic jaltoreg;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_BUBBLE     = '0;
    localparam mem_ctrl_t MEM_CTRL_BUBBLE = '0;
    localparam wb_ctrl_t  WB_CTRL_BUBBLE  = '0;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    function automatic mem_ctrl_t to_mem(input ctrl_t c);
        mem_ctrl_t m;
        m.memread  = c.memread;
        m.memwrite = c.memwrite;
        m.regwrite = c.regwrite;
        m.memtoreg = c.memtoreg;
        m.jaltoreg = c.jaltoreg;
        return m;
    endfunction

    function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
        wb_ctrl_t w;
        w.regwrite = m.regwrite;
        w.memtoreg = m.memtoreg;
        w.jaltoreg = m.jaltoreg;
        return w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational opcode decoder: turns the ID-stage opcode into a control
// bundle, producing a bubble for empty slots, HALT and unknown opcodes.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPC_W = 7
) (
    input  logic             valid_i,
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_t            ctrl_o,
    output logic             illegal_o
);

    // Decode table; anything not listed is a bubble and, if valid, illegal.
    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        illegal_o = 1'b0;
        if (valid_i) begin
            case (opcode_i)
                OPC_W'(OPC_R): begin
                    ctrl_o.aluop    = 2'b10;
                    ctrl_o.regwrite = 1'b1;
                end
                OPC_W'(OPC_I): begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.aluop    = 2'b10;
                    ctrl_o.regwrite = 1'b1;
                end
                OPC_W'(OPC_LUI): begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.aluop    = 2'b11;
                    ctrl_o.regwrite = 1'b1;
                end
                OPC_W'(OPC_LW): begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.memread  = 1'b1;
                    ctrl_o.memtoreg = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                end
                OPC_W'(OPC_SW): begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.memwrite = 1'b1;
                end
                OPC_W'(OPC_BR): begin
                    ctrl_o.aluop    = 2'b01;
                    ctrl_o.branch   = 1'b1;
                end
                OPC_W'(OPC_JAL): begin
                    ctrl_o.jal      = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.jaltoreg = 1'b1;
                end
                OPC_W'(OPC_JALR): begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.jaltoreg = 1'b1;
                end
                OPC_W'(OPC_HALT): begin
                    ctrl_o = CTRL_BUBBLE;
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries control and destination
// register through ID/EX, EX/MEM and MEM/WB, inserts load-use stalls,
// applies EX-resolved flushes and drains the pipe on HALT.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int OPC_W       = 7,
    parameter int DRAIN_CYC   = 3,
    parameter int LOAD_USE_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [OPC_W-1:0]  id_opcode_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              flush_ifid_o,
    output logic              illegal_o,
    output logic              ex_alusrc_o,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_branch_o,
    output logic              ex_jal_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              mem_memread_o,
    output logic              mem_memwrite_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic              wb_regwrite_o,
    output logic              wb_memtoreg_o,
    output logic              wb_jaltoreg_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic              halted_o
);

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ctrl_t             idexCtrl_q, idexCtrl_d;
    logic [REG_AW-1:0] exRd_q, exRd_d;
    mem_ctrl_t         memCtrl_q, memCtrl_d;
    logic [REG_AW-1:0] memRd_q, memRd_d;
    wb_ctrl_t          wbCtrl_q, wbCtrl_d;
    logic [REG_AW-1:0] wbRd_q, wbRd_d;

    ctrl_t             decCtrl;
    logic              decIllegal;
    logic              idHalt;
    logic              rs2Used;
    logic              loadUse;
    logic [REG_AW-1:0] decRd;

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .valid_i   (id_valid_i),
        .opcode_i  (id_opcode_i),
        .ctrl_o    (decCtrl),
        .illegal_o (decIllegal)
    );

    assign illegal_o = decIllegal;

    // Hazard detection: a load in EX whose non-x0 target feeds a source
    // register actually read by the instruction in ID.
    always_comb begin
        idHalt  = id_valid_i && (id_opcode_i == OPC_W'(OPC_HALT));
        rs2Used = (id_opcode_i == OPC_W'(OPC_R))  ||
                  (id_opcode_i == OPC_W'(OPC_SW)) ||
                  (id_opcode_i == OPC_W'(OPC_BR));
        loadUse = (LOAD_USE_EN != 0) && id_valid_i && idexCtrl_q.memread &&
                  (exRd_q != '0) &&
                  ((exRd_q == id_rs1_i) || (rs2Used && (exRd_q == id_rs2_i)));
        decRd   = (id_valid_i && !decIllegal && !idHalt) ? id_rd_i : '0;
    end

    // Next-state and stage-register loading; later stages always advance
    // unless the core is halted, ID/EX takes a bubble on any hold condition.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idexCtrl_d   = CTRL_BUBBLE;
        exRd_d       = '0;
        memCtrl_d    = to_mem(idexCtrl_q);
        memRd_d      = exRd_q;
        wbCtrl_d     = to_wb(memCtrl_q);
        wbRd_d       = memRd_q;
        stall_o      = 1'b0;
        flush_ifid_o = 1'b0;
        halted_o     = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_i) begin
                    flush_ifid_o = 1'b1;
                end else if (loadUse) begin
                    stall_o = 1'b1;
                end else if (idHalt) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYC - 1);
                end else begin
                    idexCtrl_d = decCtrl;
                    exRd_d     = decRd;
                end
            end
            DRAIN: begin
                stall_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HALTED: begin
                stall_o   = 1'b1;
                halted_o  = 1'b1;
                memCtrl_d = MEM_CTRL_BUBBLE;
                memRd_d   = '0;
                wbCtrl_d  = WB_CTRL_BUBBLE;
                wbRd_d    = '0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, drain counter and pipeline control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            idexCtrl_q <= CTRL_BUBBLE;
            exRd_q     <= '0;
            memCtrl_q  <= MEM_CTRL_BUBBLE;
            memRd_q    <= '0;
            wbCtrl_q   <= WB_CTRL_BUBBLE;
            wbRd_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idexCtrl_q <= idexCtrl_d;
            exRd_q     <= exRd_d;
            memCtrl_q  <= memCtrl_d;
            memRd_q    <= memRd_d;
            wbCtrl_q   <= wbCtrl_d;
            wbRd_q     <= wbRd_d;
        end
    end

    assign ex_alusrc_o    = idexCtrl_q.alusrc;
    assign ex_aluop_o     = idexCtrl_q.aluop;
    assign ex_branch_o    = idexCtrl_q.branch;
    assign ex_jal_o       = idexCtrl_q.jal;
    assign ex_rd_o        = exRd_q;
    assign mem_memread_o  = memCtrl_q.memread;
    assign mem_memwrite_o = memCtrl_q.memwrite;
    assign mem_rd_o       = memRd_q;
    assign wb_regwrite_o  = wbCtrl_q.regwrite;
    assign wb_memtoreg_o  = wbCtrl_q.memtoreg;
    assign wb_jaltoreg_o  = wbCtrl_q.jaltoreg;
    assign wb_rd_o        = wbRd_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_pipe_ctrl_unit;

    localparam int DRAIN_CYC = 3;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b0000000;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid_i;
    logic [6:0] id_opcode_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic       flush_i;
    logic       stall_o, flush_ifid_o, illegal_o;
    logic       ex_alusrc_o, ex_branch_o, ex_jal_o;
    logic [1:0] ex_aluop_o;
    logic [4:0] ex_rd_o, mem_rd_o, wb_rd_o;
    logic       mem_memread_o, mem_memwrite_o;
    logic       wb_regwrite_o, wb_memtoreg_o, wb_jaltoreg_o;
    logic       halted_o;

    pipe_ctrl_unit #(
        .REG_AW(5), .OPC_W(7), .DRAIN_CYC(DRAIN_CYC), .LOAD_USE_EN(1)
    ) dut (
        .clk(clk), .reset(reset),
        .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .flush_i(flush_i),
        .stall_o(stall_o), .flush_ifid_o(flush_ifid_o), .illegal_o(illegal_o),
        .ex_alusrc_o(ex_alusrc_o), .ex_aluop_o(ex_aluop_o),
        .ex_branch_o(ex_branch_o), .ex_jal_o(ex_jal_o), .ex_rd_o(ex_rd_o),
        .mem_memread_o(mem_memread_o), .mem_memwrite_o(mem_memwrite_o),
        .mem_rd_o(mem_rd_o),
        .wb_regwrite_o(wb_regwrite_o), .wb_memtoreg_o(wb_memtoreg_o),
        .wb_jaltoreg_o(wb_jaltoreg_o), .wb_rd_o(wb_rd_o),
        .halted_o(halted_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Model stage contents: bits {alusrc, aluop[1:0], branch, jal,
    // memread, memwrite, regwrite, memtoreg, jaltoreg} plus destination.
    typedef struct packed {
        logic [9:0] c;
        logic [4:0] rd;
    } stage_t;

    stage_t mEx, mMem, mWb;
    int     drainLeft;
    bit     mHalted;
    logic   lastStall, lastFlush, lastIllegal;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference control table taken straight from the instruction set.
    function automatic bit lookup(input logic [6:0] opc, output logic [9:0] c);
        bit known = 1'b1;
        case (opc)
            OP_R:    c = 10'b0_10_0_0_0_0_1_0_0;
            OP_I:    c = 10'b1_10_0_0_0_0_1_0_0;
            OP_LUI:  c = 10'b1_11_0_0_0_0_1_0_0;
            OP_LW:   c = 10'b1_00_0_0_1_0_1_1_0;
            OP_SW:   c = 10'b1_00_0_0_0_1_0_0_0;
            OP_BR:   c = 10'b0_01_1_0_0_0_0_0_0;
            OP_JAL:  c = 10'b0_00_0_1_0_0_1_0_1;
            OP_JALR: c = 10'b1_00_0_0_0_0_1_0_1;
            OP_HALT: c = 10'b0;
            default: begin
                c     = 10'b0;
                known = 1'b0;
            end
        endcase
        return known;
    endfunction

    task automatic modelReset();
        mEx       = '0;
        mMem      = '0;
        mWb       = '0;
        drainLeft = 0;
        mHalted   = 1'b0;
    endtask

    task automatic applyReset();
        reset       = 1'b1;
        id_valid_i  = 1'b0;
        id_opcode_i = 7'b0;
        id_rs1_i    = 5'd0;
        id_rs2_i    = 5'd0;
        id_rd_i     = 5'd0;
        flush_i     = 1'b0;
        @(negedge clk);
        checkOutput("resetState",
                    32'({ex_alusrc_o, ex_aluop_o, ex_branch_o, ex_jal_o, ex_rd_o,
                         mem_memread_o, mem_memwrite_o, mem_rd_o,
                         wb_regwrite_o, wb_memtoreg_o, wb_jaltoreg_o, wb_rd_o,
                         halted_o}), 32'd0);
        reset = 1'b0;
        modelReset();
    endtask

    // One clock cycle: check registered outputs, drive ID, check the
    // combinational outputs, advance the model, move to the next negedge.
    task automatic applyStimulus(input bit v, input logic [6:0] opc,
                                 input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] d, input bit f);
        logic [9:0] c;
        bit         known, running, isHalt, rs2used, hazard;
        stage_t     nEx;
        checkOutput("exCtrl", 32'({ex_alusrc_o, ex_aluop_o, ex_branch_o, ex_jal_o}),
                    32'(mEx.c[9:5]));
        checkOutput("exRd", 32'(ex_rd_o), 32'(mEx.rd));
        checkOutput("memCtrl", 32'({mem_memread_o, mem_memwrite_o}), 32'(mMem.c[4:3]));
        checkOutput("memRd", 32'(mem_rd_o), 32'(mMem.rd));
        checkOutput("wbCtrl", 32'({wb_regwrite_o, wb_memtoreg_o, wb_jaltoreg_o}),
                    32'(mWb.c[2:0]));
        checkOutput("wbRd", 32'(wb_rd_o), 32'(mWb.rd));
        checkOutput("halted", 32'(halted_o), 32'(mHalted));

        id_valid_i  = v;
        id_opcode_i = opc;
        id_rs1_i    = a;
        id_rs2_i    = b;
        id_rd_i     = d;
        flush_i     = f;
        #1;
        known   = lookup(opc, c);
        running = !mHalted && (drainLeft == 0);
        isHalt  = v && (opc == OP_HALT);
        rs2used = (opc == OP_R) || (opc == OP_SW) || (opc == OP_BR);
        hazard  = running && v && mEx.c[4] && (mEx.rd != 5'd0) &&
                  ((mEx.rd == a) || (rs2used && (mEx.rd == b)));
        lastStall   = stall_o;
        lastFlush   = flush_ifid_o;
        lastIllegal = illegal_o;
        checkOutput("stall", 32'(stall_o), 32'(!running || (!f && hazard)));
        checkOutput("flushIfid", 32'(flush_ifid_o), 32'(running && f));
        checkOutput("illegal", 32'(illegal_o), 32'(v && !known));

        nEx = '0;
        if (running && !f && !hazard && !isHalt && v && known) nEx = {c, d};
        mWb  = mHalted ? '0 : mMem;
        mMem = mHalted ? '0 : mEx;
        mEx  = nEx;
        if (!mHalted) begin
            if (drainLeft > 0) begin
                drainLeft--;
                if (drainLeft == 0) mHalted = 1'b1;
            end else if (!f && !hazard && isHalt) begin
                drainLeft = DRAIN_CYC;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 7'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // Directed scenarios first, then randomized traffic.
    initial begin
        logic [6:0] legalOps [8];
        logic [6:0] badOps   [3];
        int         haltedCycles;
        legalOps = '{OP_R, OP_I, OP_LUI, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
        badOps   = '{7'b1111111, 7'b0000001, 7'b1010101};

        applyReset();

        // R-type through the pipe
        applyStimulus(1'b1, OP_R, 5'd1, 5'd2, 5'd5, 1'b0);
        checkOutput("rAluop", 32'(ex_aluop_o), 32'd2);
        checkOutput("rExRd", 32'(ex_rd_o), 32'd5);
        idle();
        idle();
        checkOutput("rWbWrite", 32'(wb_regwrite_o), 32'd1);
        checkOutput("rWbRd", 32'(wb_rd_o), 32'd5);

        // load-use on rs1: one stall cycle, bubble, then ADD enters EX
        applyStimulus(1'b1, OP_LW, 5'd1, 5'd0, 5'd3, 1'b0);
        applyStimulus(1'b1, OP_R, 5'd3, 5'd0, 5'd4, 1'b0);
        checkOutput("luStall", 32'(lastStall), 32'd1);
        checkOutput("luBubble", 32'({ex_alusrc_o, ex_aluop_o, ex_rd_o}), 32'd0);
        checkOutput("luOneCycle", 32'(stall_o), 32'd0);
        applyStimulus(1'b1, OP_R, 5'd3, 5'd0, 5'd4, 1'b0);
        checkOutput("luRelease", 32'(ex_rd_o), 32'd4);

        // x0 never a hazard source
        applyStimulus(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, OP_R, 5'd0, 5'd0, 5'd6, 1'b0);
        checkOutput("luX0", 32'(lastStall), 32'd0);

        // SW uses rs2, I-type does not
        applyStimulus(1'b1, OP_LW, 5'd1, 5'd0, 5'd3, 1'b0);
        applyStimulus(1'b1, OP_SW, 5'd1, 5'd3, 5'd0, 1'b0);
        checkOutput("luSwRs2", 32'(lastStall), 32'd1);
        idle();
        applyStimulus(1'b1, OP_LW, 5'd1, 5'd0, 5'd3, 1'b0);
        applyStimulus(1'b1, OP_I, 5'd1, 5'd3, 5'd2, 1'b0);
        checkOutput("luIRs2", 32'(lastStall), 32'd0);

        // flush wins over load-use
        applyStimulus(1'b1, OP_LW, 5'd1, 5'd0, 5'd3, 1'b0);
        applyStimulus(1'b1, OP_R, 5'd3, 5'd0, 5'd4, 1'b1);
        checkOutput("flushStall", 32'(lastStall), 32'd0);
        checkOutput("flushIfidSet", 32'(lastFlush), 32'd1);
        checkOutput("flushBubble", 32'({ex_alusrc_o, ex_aluop_o, ex_rd_o}), 32'd0);

        // JAL and illegal opcode
        applyStimulus(1'b1, OP_JAL, 5'd0, 5'd0, 5'd1, 1'b0);
        checkOutput("jalEx", 32'(ex_jal_o), 32'd1);
        applyStimulus(1'b1, 7'b1111111, 5'd1, 5'd1, 5'd7, 1'b0);
        checkOutput("illegalFlag", 32'(lastIllegal), 32'd1);
        idle();
        checkOutput("jalWb", 32'({wb_regwrite_o, wb_jaltoreg_o, wb_rd_o}), 32'h61);
        idle();
        idle();

        // HALT squashed by flush, then real HALT timing
        applyStimulus(1'b1, OP_HALT, 5'd0, 5'd0, 5'd0, 1'b1);
        idle();
        checkOutput("haltSquash", 32'(stall_o), 32'd0);
        applyStimulus(1'b1, OP_HALT, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            checkOutput("haltTiming", 32'(halted_o), 32'(k >= 4));
            applyStimulus(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b1);
        end
        applyReset();
        idle();

        // reset in the middle of DRAIN
        applyStimulus(1'b1, OP_HALT, 5'd0, 5'd0, 5'd0, 1'b0);
        idle();
        idle();
        applyReset();
        idle();

        // randomized traffic
        haltedCycles = 0;
        for (int n = 0; n < 3000; n++) begin
            int         r;
            logic [6:0] opc;
            r = int'($urandom_range(0, 99));
            if (r < 3)      opc = OP_HALT;
            else if (r < 8) opc = badOps[$urandom_range(0, 2)];
            else            opc = legalOps[$urandom_range(0, 7)];
            applyStimulus($urandom_range(0, 99) < 85, opc,
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), $urandom_range(0, 99) < 10);
            haltedCycles = mHalted ? haltedCycles + 1 : 0;
            if (haltedCycles >= 3 || $urandom_range(0, 199) == 0) begin
                applyReset();
                haltedCycles = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
